// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive-side byte FIFO fed by a UART receiver's frame-done level,
//            with a registered pop handshake and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_50,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_ready,
    input  logic                  rd_en,
    input  logic                  clr_overflow,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam logic [DEPTH_LOG2:0] c_depth = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_zero  = '0;

    logic [DATA_W-1:0]     r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic                  r_rx_ready_q;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_acc;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // A frame is captured only on the rising edge of the receiver's level.
    assign w_push      = rx_ready & ~r_rx_ready_q;
    assign w_pop       = rd_en & (count != c_zero);
    // When full, a same-cycle pop frees the slot the push will land in.
    assign w_push_acc  = w_push & ((count != c_depth) | w_pop);
    assign w_drop      = w_push & ~w_push_acc;
    assign w_count_nxt = count + {{DEPTH_LOG2{1'b0}}, w_push_acc}
                               - {{DEPTH_LOG2{1'b0}}, w_pop};

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_rx_ready_q <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_rx_ready_q <= rx_ready;
            count        <= w_count_nxt;
            empty        <= (w_count_nxt == c_zero);
            full         <= (w_count_nxt == c_depth);
            rd_valid     <= w_pop;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                rd_data  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Randomised scoreboard bench for uart_rx_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_depth = 16;

    logic       clk_50 = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rd_en       (rd_en),
        .clr_overflow(clr_overflow),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // Reference model: stored bytes, expected pops, and flag state.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_prev_rr;
    logic       m_ovf;
    logic       m_rv;
    logic [7:0] m_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every presented byte must match the next expected pop.
    always @(negedge clk_50) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_stream: got 0x%02h expected none", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_stream: got 0x%02h expected 0x%02h", rd_data, e);
                end
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, ".count"},    int'(count),    m_q.size());
        chk({tag, ".empty"},    int'(empty),    int'(m_q.size() == 0));
        chk({tag, ".full"},     int'(full),     int'(m_q.size() == c_depth));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(m_rv));
        chk({tag, ".rd_data"},  int'(rd_data),  int'(m_last));
    endtask

    // One clock: apply inputs, advance the model at the edge, then check.
    task automatic cycle(input logic rr, input logic [7:0] d, input logic re, input logic clr);
        logic push;
        logic pop;
        rx_ready = rr; rx_data = d; rd_en = re; clr_overflow = clr;
        @(posedge clk_50);
        push = rr && !m_prev_rr;
        pop  = re && (m_q.size() > 0);
        m_rv = pop;
        if (pop) begin
            m_last = m_q.pop_front();
            exp_q.push_back(m_last);
        end
        if (push && (m_q.size() < c_depth)) m_q.push_back(d);
        else if (push)                      m_ovf = 1'b1;
        else if (clr)                       m_ovf = 1'b0;
        if (push && (m_q.size() == c_depth) && !pop && clr) m_ovf = 1'b1;
        m_prev_rr = rr;
        #1;
        check_state("cyc");
    endtask

    task automatic frame(input logic [7:0] d, input int hi, input int lo, input int pop_pct);
        for (int i = 0; i < hi; i++)
            cycle(1'b1, d, ($urandom_range(99) < pop_pct), 1'b0);
        for (int i = 0; i < lo; i++)
            cycle(1'b0, 8'($urandom), ($urandom_range(99) < pop_pct), 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input logic rr);
        rx_ready = rr; rst = 1'b1;
        m_q.delete(); m_prev_rr = 1'b1; m_ovf = 1'b0; m_rv = 1'b0; m_last = 8'h00;
        #1;
        check_state("rst");
        repeat (3) @(posedge clk_50);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rx_data = 8'h00; rx_ready = 1'b1; rd_en = 1'b0; clr_overflow = 1'b0;
        m_prev_rr = 1'b1; m_ovf = 1'b0; m_rv = 1'b0; m_last = 8'h00;
        #3;

        // 1: receiver level already high through reset release
        do_reset(1'b1);
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("t1.count", int'(count), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 2: one long frame, one push
        frame(8'hA5, 5208, 3, 0);
        chk("t2.count", int'(count), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2.rd_data", int'(rd_data), 8'hA5);
        chk("t2.empty", int'(empty), 1);

        // 3: fill, overrun, drain in order
        for (int b = 0; b < 16; b++) frame(8'(b), 2, 2, 0);
        chk("t3.full", int'(full), 1);
        frame(8'h55, 3, 2, 0);
        chk("t3.overflow", int'(overflow), 1);
        drain(18);
        chk("t3.empty", int'(empty), 1);

        // 4: push coincident with pop while full
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int b = 0; b < 16; b++) frame(8'(8'h10 + b), 1, 1, 0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4.count", int'(count), 16);
        chk("t4.overflow", int'(overflow), 0);
        frame(8'h77, 2, 2, 0);
        drain(17);
        chk("t4.last", int'(rd_data), 8'h77);

        // 5: random interleaving across pointer wraps
        for (int n = 0; n < 40; n++)
            frame(8'($urandom), $urandom_range(1, 6), $urandom_range(1, 4), 45);
        drain(20);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5.rd_valid_empty", int'(rd_valid), 0);

        // 6: drop with simultaneous clear, clear alone, reset with data stored
        for (int b = 0; b < 16; b++) frame(8'($urandom), 1, 1, 0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        chk("t6.set_wins", int'(overflow), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6.clr", int'(overflow), 0);
        drain(17);
        for (int b = 0; b < 5; b++) frame(8'($urandom), 1, 1, 0);
        chk("t6.count5", int'(count), 5);
        do_reset(1'b0);
        chk("t6.post_rst_count", int'(count), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        chk("scoreboard_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
